// File: rtl/sg_chain.sv
// Segmented-loop FSM: IDLE, NSEG chained HEAD/BODY loop segments, a DRAIN_LEN-cycle
// drain chain, then an absorbing SINK. Counts completed body->head transitions.
module sg_chain #(
    parameter int  NSEG      = 3,
    parameter int  DRAIN_LEN = 4,
    parameter int  CW        = 4,
    localparam int SW        = (NSEG > 1) ? $clog2(NSEG) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          i,
    input  logic          abort,
    output logic          o,
    output logic          in_loop,
    output logic          in_sink,
    output logic [SW-1:0] seg,
    output logic [CW-1:0] visits
);

    localparam int DW = $clog2(DRAIN_LEN) + 1;

    localparam logic [SW-1:0] SEG_LAST  = SW'(NSEG - 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DRAIN_LEN - 1);
    localparam logic [CW-1:0] VIS_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        BODY,
        DRAIN,
        SINK
    } kind_e;

    kind_e         kind_q, kind_d;
    logic [SW-1:0] seg_q, seg_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [CW-1:0] visits_q, visits_d;

    always_comb begin
        kind_d   = kind_q;
        seg_d    = seg_q;
        dcnt_d   = dcnt_q;
        visits_d = visits_q;
        unique case (kind_q)
            IDLE: begin
                if (abort) begin
                    kind_d = DRAIN;
                    seg_d  = '0;
                    dcnt_d = '0;
                end else if (i) begin
                    kind_d = HEAD;
                    seg_d  = '0;
                end
            end
            HEAD: begin
                if (abort || !i) begin
                    kind_d = DRAIN;
                    seg_d  = '0;
                    dcnt_d = '0;
                end else begin
                    kind_d = BODY;
                end
            end
            BODY: begin
                if (abort) begin
                    kind_d = DRAIN;
                    seg_d  = '0;
                    dcnt_d = '0;
                end else begin
                    // Both i and !i close the loop back to a HEAD, so visits counts either way.
                    kind_d = HEAD;
                    if (i) begin
                        seg_d = (seg_q == SEG_LAST) ? '0 : seg_q + 1'b1;
                    end
                    if (visits_q != VIS_MAX) begin
                        visits_d = visits_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Inputs are not read here so unknowns on i/abort cannot disturb the drain.
                if (dcnt_q == DCNT_LAST) begin
                    kind_d = SINK;
                    dcnt_d = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            SINK: begin
                kind_d = SINK;
            end
            default: begin
                kind_d = IDLE;
                seg_d  = '0;
                dcnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            kind_q   <= IDLE;
            seg_q    <= '0;
            dcnt_q   <= '0;
            visits_q <= '0;
        end else begin
            kind_q   <= kind_d;
            seg_q    <= seg_d;
            dcnt_q   <= dcnt_d;
            visits_q <= visits_d;
        end
    end

    assign o       = (kind_q == IDLE);
    assign in_loop = (kind_q == HEAD) || (kind_q == BODY);
    assign in_sink = (kind_q == SINK);
    assign seg     = seg_q;
    assign visits  = visits_q;

endmodule

// File: tb/tb_sg_chain.sv
// Scoreboard bench for sg_chain: defaults, a CW=2 instance and a NSEG=1/DRAIN_LEN=1 instance.
module tb_sg_chain;

    logic clock = 1'b0;
    logic rst1 = 1'b0, rst2 = 1'b0, rst3 = 1'b0;
    logic i = 1'b0, abort = 1'b0;

    logic       o1, l1, s1, o2, l2, s2, o3, l3, s3;
    logic [1:0] seg1, seg2;
    logic [0:0] seg3;
    logic [3:0] vis1, vis3;
    logic [1:0] vis2;

    int         sel = 1;
    int         errors = 0;
    int         checks = 0;
    logic [8:0] obs;
    logic [8:0] exp_v;
    logic [8:0] exp_q[$];

    always #5 clock = ~clock;

    sg_chain #(.NSEG(3), .DRAIN_LEN(4), .CW(4)) dut1 (
        .clock(clock), .reset_n(rst1), .i(i), .abort(abort),
        .o(o1), .in_loop(l1), .in_sink(s1), .seg(seg1), .visits(vis1)
    );

    sg_chain #(.NSEG(3), .DRAIN_LEN(4), .CW(2)) dut2 (
        .clock(clock), .reset_n(rst2), .i(i), .abort(abort),
        .o(o2), .in_loop(l2), .in_sink(s2), .seg(seg2), .visits(vis2)
    );

    sg_chain #(.NSEG(1), .DRAIN_LEN(1), .CW(4)) dut3 (
        .clock(clock), .reset_n(rst3), .i(i), .abort(abort),
        .o(o3), .in_loop(l3), .in_sink(s3), .seg(seg3), .visits(vis3)
    );

    always_comb begin
        case (sel)
            2:       obs = {o2, l2, s2, seg2, 2'b00, vis2};
            3:       obs = {o3, l3, s3, 1'b0, seg3, vis3};
            default: obs = {o1, l1, s1, seg1, vis1};
        endcase
    end

    function automatic logic [8:0] mk(input logic eo, input logic el, input logic es,
                                      input int eseg, input int evis);
        return {eo, el, es, 2'(eseg), 4'(evis)};
    endfunction

    task automatic do_reset();
        rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        i = 1'b0; abort = 1'b0;
        exp_q.delete();
        @(posedge clock); #1;
        rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    endtask

    task automatic test_reset();
        sel = 1;
        rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        i = 1'b1; abort = 1'b0;
        for (int n = 0; n < 3; n++) begin
            exp_q.push_back(mk(1, 0, 0, 0, 0));
            @(posedge clock); #1;
            exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL reset_hold cyc %0d: got %b want %b", n, obs, exp_v);
            end
        end
        rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        exp_q.push_back(mk(0, 1, 0, 0, 0));
        @(posedge clock); #1;
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL reset_release: got %b want %b", obs, exp_v);
        end
        rst1 = 1'b0;
        exp_q.push_back(mk(1, 0, 0, 0, 0));
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL reset_async: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_idle_hold();
        sel = 1;
        do_reset();
        for (int n = 1; n <= 10; n++) begin
            i = 1'b0; abort = 1'b0;
            exp_q.push_back(mk(1, 0, 0, 0, 0));
            @(posedge clock); #1;
            exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL idle_hold cyc %0d: got %b want %b", n, obs, exp_v);
            end
        end
    endtask

    task automatic test_loop_walk();
        int seg_t[7] = '{0, 0, 1, 1, 2, 2, 0};
        int vis_t[7] = '{0, 0, 1, 1, 2, 2, 3};
        sel = 1;
        do_reset();
        for (int n = 0; n < 7; n++) begin
            i = 1'b1; abort = 1'b0;
            exp_q.push_back(mk(0, 1, 0, seg_t[n], vis_t[n]));
            @(posedge clock); #1;
            exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL loop_walk cyc %0d: got %b want %b", n + 1, obs, exp_v);
            end
        end
    endtask

    task automatic test_exit_sink();
        logic [3:0] i_t = 4'b0011;
        sel = 1;
        do_reset();
        for (int n = 1; n <= 27; n++) begin
            if (n <= 4) begin
                i = i_t[n-1]; abort = 1'b0;
            end else if (n <= 5) begin
                i = 1'bx; abort = 1'bx;
            end else begin
                i = 1'($urandom_range(0, 1)); abort = 1'($urandom_range(0, 1));
            end
            if (n <= 2)      exp_q.push_back(mk(0, 1, 0, 0, 0));
            else if (n == 3) exp_q.push_back(mk(0, 1, 0, 0, 1));
            else if (n <= 7) exp_q.push_back(mk(0, 0, 0, 0, 1));
            else             exp_q.push_back(mk(0, 0, 1, 0, 1));
            @(posedge clock); #1;
            exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL exit_sink cyc %0d: got %b want %b", n, obs, exp_v);
            end
        end
    endtask

    task automatic test_abort();
        sel = 1;
        do_reset();
        for (int n = 1; n <= 9; n++) begin
            if (n <= 4) begin
                i = 1'b1; abort = 1'b0;
                exp_q.push_back(mk(0, 1, 0, (n - 1) / 2, (n >= 3) ? 1 : 0));
            end else if (n == 5) begin
                i = 1'b1; abort = 1'b1;
                exp_q.push_back(mk(0, 0, 0, 0, 1));
            end else begin
                i = 1'($urandom_range(0, 1)); abort = 1'($urandom_range(0, 1));
                exp_q.push_back((n < 9) ? mk(0, 0, 0, 0, 1) : mk(0, 0, 1, 0, 1));
            end
            @(posedge clock); #1;
            exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL abort_body cyc %0d: got %b want %b", n, obs, exp_v);
            end
        end
        do_reset();
        i = 1'b1; abort = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        @(posedge clock); #1;
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL abort_idle: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_saturation();
        sel = 2;
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            i = 1'b1; abort = 1'b0;
            exp_q.push_back(mk(0, 1, 0, ((n - 1) / 2) % 3, ((n - 1) / 2 > 3) ? 3 : (n - 1) / 2));
            @(posedge clock); #1;
            exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL saturate cyc %0d: got %b want %b", n, obs, exp_v);
            end
        end
        for (int n = 1; n <= 3; n++) begin
            i = 1'b0; abort = 1'b0;
            exp_q.push_back((n == 1) ? mk(0, 1, 0, 0, 3) : mk(0, 0, 0, 0, 3));
            @(posedge clock); #1;
            exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL sat_exit cyc %0d: got %b want %b", n, obs, exp_v);
            end
        end
        #1 rst2 = 1'b0;
        exp_q.push_back(mk(1, 0, 0, 0, 0));
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL mid_drain_reset: got %b want %b", obs, exp_v);
        end
        i = 1'b1;
        exp_q.push_back(mk(1, 0, 0, 0, 0));
        @(posedge clock); #1;
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL reset_held: got %b want %b", obs, exp_v);
        end
        rst2 = 1'b1;
        exp_q.push_back(mk(0, 1, 0, 0, 0));
        @(posedge clock); #1;
        exp_v = exp_q.pop_front(); checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL resume_idle: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_single_seg();
        logic [7:0] i_t = 8'b0000_0011_111 >> 0;
        sel = 3;
        do_reset();
        i_t = 8'b0001_1111;
        for (int n = 1; n <= 8; n++) begin
            i = i_t[n-1]; abort = 1'b0;
            if (n <= 5)      exp_q.push_back(mk(0, 1, 0, 0, (n - 1) / 2));
            else if (n == 6) exp_q.push_back(mk(0, 0, 0, 0, 2));
            else             exp_q.push_back(mk(0, 0, 1, 0, 2));
            @(posedge clock); #1;
            exp_v = exp_q.pop_front(); checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL single_seg cyc %0d: got %b want %b", n, obs, exp_v);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_idle_hold();
        test_loop_walk();
        test_exit_sink();
        test_abort();
        test_saturation();
        test_single_seg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
